// File: rtl/hololink_init_seq_pkg.sv
// rtl/hololink_init_seq_pkg.sv - shared types and defaults for the init-table APB sequencer
package hololink_init_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_DLY,
        SETUP,
        ACCESS,
        NEXT,
        DONE
    } init_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } init_entry_t;

    localparam int INIT_TIMEOUT   = 1024;
    localparam int INIT_START_DLY = 64;

endpackage

// File: rtl/hololink_init_seq.sv
// rtl/hololink_init_seq.sv - writes the init register table over APB, then passes the host master through
module hololink_init_seq
    import hololink_init_seq_pkg::*;
#(
    parameter int N_INIT_REG = 9,
    parameter int START_DLY  = INIT_START_DLY,
    parameter int TIMEOUT    = INIT_TIMEOUT,
    parameter int IDX_W      = (N_INIT_REG > 1) ? $clog2(N_INIT_REG) : 1
) (
    input  logic             i_apb_clk,
    input  logic             i_apb_rst,
    output logic [IDX_W-1:0] o_init_idx,
    input  logic [63:0]      i_init_entry,
    input  logic             i_restart,
    output logic             o_init_busy,
    output logic             o_init_done,
    output logic             o_init_err,
    output logic [IDX_W-1:0] o_err_idx,
    input  logic             s_apb_psel,
    input  logic             s_apb_penable,
    input  logic             s_apb_pwrite,
    input  logic [31:0]      s_apb_paddr,
    input  logic [31:0]      s_apb_pwdata,
    output logic [31:0]      s_apb_prdata,
    output logic             s_apb_pready,
    output logic             s_apb_pslverr,
    output logic             m_apb_psel,
    output logic             m_apb_penable,
    output logic             m_apb_pwrite,
    output logic [31:0]      m_apb_paddr,
    output logic [31:0]      m_apb_pwdata,
    input  logic [31:0]      m_apb_prdata,
    input  logic             m_apb_pready,
    input  logic             m_apb_pslverr
);

    localparam int DLY_W = (START_DLY > 0) ? $clog2(START_DLY + 1) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INIT_REG - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((START_DLY > 0) ? START_DLY - 1 : 0);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    init_state_t      state, next_state;
    logic [DLY_W-1:0] dly_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] err_idx;
    logic             err;
    init_entry_t      entry, entry_q;
    logic             rec_err;
    logic             restart_go;

    assign entry       = init_entry_t'(i_init_entry);
    assign o_init_idx  = idx;
    assign o_init_err  = err;
    assign o_err_idx   = err_idx;
    assign o_init_busy = (state != DONE);
    assign o_init_done = (state == DONE);
    assign restart_go  = (state == DONE) && i_restart && !s_apb_psel;

    always_comb begin
        next_state    = state;
        rec_err       = 1'b0;
        m_apb_psel    = 1'b0;
        m_apb_penable = 1'b0;
        m_apb_pwrite  = 1'b0;
        m_apb_paddr   = '0;
        m_apb_pwdata  = '0;
        s_apb_prdata  = '0;
        s_apb_pready  = 1'b0;
        s_apb_pslverr = 1'b0;
        case (state)
            WAIT_DLY: begin
                if (START_DLY == 0 || dly_cnt == DLY_LAST)
                    next_state = SETUP;
            end
            SETUP: begin
                // Address phase drives the table entry directly; ACCESS replays the captured copy.
                m_apb_psel   = 1'b1;
                m_apb_pwrite = 1'b1;
                m_apb_paddr  = entry.addr;
                m_apb_pwdata = entry.data;
                next_state   = ACCESS;
            end
            ACCESS: begin
                m_apb_psel    = 1'b1;
                m_apb_penable = 1'b1;
                m_apb_pwrite  = 1'b1;
                m_apb_paddr   = entry_q.addr;
                m_apb_pwdata  = entry_q.data;
                if (m_apb_pready) begin
                    rec_err    = m_apb_pslverr;
                    next_state = NEXT;
                end else if (to_cnt == TO_LAST) begin
                    rec_err    = 1'b1;
                    next_state = NEXT;
                end
            end
            NEXT: begin
                next_state = (idx == LAST_IDX) ? DONE : SETUP;
            end
            DONE: begin
                m_apb_psel    = s_apb_psel;
                m_apb_penable = s_apb_penable;
                m_apb_pwrite  = s_apb_pwrite;
                m_apb_paddr   = s_apb_paddr;
                m_apb_pwdata  = s_apb_pwdata;
                s_apb_prdata  = m_apb_prdata;
                s_apb_pready  = m_apb_pready;
                s_apb_pslverr = m_apb_pslverr;
                if (restart_go)
                    next_state = SETUP;
            end
            default: next_state = WAIT_DLY;
        endcase
    end

    always_ff @(posedge i_apb_clk or posedge i_apb_rst) begin
        if (i_apb_rst) begin
            state   <= WAIT_DLY;
            dly_cnt <= '0;
            to_cnt  <= '0;
            idx     <= '0;
            entry_q <= '0;
            err     <= 1'b0;
            err_idx <= '0;
        end else begin
            state <= next_state;
            if (state == WAIT_DLY && dly_cnt != '1)
                dly_cnt <= dly_cnt + 1'b1;
            if (state == ACCESS)
                to_cnt <= (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;
            else
                to_cnt <= '0;
            if (state == SETUP)
                entry_q <= entry;
            if (state == NEXT && idx != LAST_IDX)
                idx <= idx + 1'b1;
            if (restart_go) begin
                idx     <= '0;
                err     <= 1'b0;
                err_idx <= '0;
            end else if (rec_err) begin
                // First failure since restart/reset keeps its index.
                err <= 1'b1;
                if (!err)
                    err_idx <= idx;
            end
        end
    end

endmodule

// File: tb/tb_hololink_init_seq.sv
// tb/tb_hololink_init_seq.sv - directed self-checking bench for hololink_init_seq
module tb_hololink_init_seq;

    localparam int N  = 9;
    localparam int DL = 64;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  init_idx;
    logic [63:0] init_entry;
    logic        restart = 1'b0;
    logic        busy, done, ierr;
    logic [3:0]  err_idx;
    logic        s_psel = 1'b0, s_penable = 1'b0, s_pwrite = 1'b0;
    logic [31:0] s_paddr = '0, s_pwdata = '0;
    logic [31:0] s_prdata;
    logic        s_pready, s_pslverr;
    logic        m_psel, m_penable, m_pwrite;
    logic [31:0] m_paddr, m_pwdata;
    logic [31:0] m_prdata;
    logic        m_pready, m_pslverr;

    logic [31:0] addr_tab [N] = '{32'h0300_0210, 32'h0300_0214, 32'h0300_0300, 32'h0300_0304,
                                  32'h0300_0400, 32'h0300_1000, 32'h0300_1004, 32'h0300_2000,
                                  32'h0300_2008};
    logic [31:0] data_tab [N] = '{32'h004C_4B40, 32'h0000_0001, 32'h1234_5678, 32'hA5A5_5A5A,
                                  32'h0000_FFFF, 32'h8000_0000, 32'h0000_0003, 32'hCAFE_F00D,
                                  32'h0000_0064};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // slave behaviour knobs (-1 = none)
    int wait_entry = -1, err_entry = -1, hang_entry = -1;
    int wcnt = 0;
    int need;
    logic hang_now;

    // monitor logs
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          att_idx [$];
    int          acc [N];
    int          unstable = 0, stall_viol = 0;
    logic [31:0] cap_addr, cap_data;

    hololink_init_seq #(.N_INIT_REG(N), .START_DLY(DL), .TIMEOUT(TO)) dut (
        .i_apb_clk(clk), .i_apb_rst(rst),
        .o_init_idx(init_idx), .i_init_entry(init_entry), .i_restart(restart),
        .o_init_busy(busy), .o_init_done(done), .o_init_err(ierr), .o_err_idx(err_idx),
        .s_apb_psel(s_psel), .s_apb_penable(s_penable), .s_apb_pwrite(s_pwrite),
        .s_apb_paddr(s_paddr), .s_apb_pwdata(s_pwdata), .s_apb_prdata(s_prdata),
        .s_apb_pready(s_pready), .s_apb_pslverr(s_pslverr),
        .m_apb_psel(m_psel), .m_apb_penable(m_penable), .m_apb_pwrite(m_pwrite),
        .m_apb_paddr(m_paddr), .m_apb_pwdata(m_pwdata), .m_apb_prdata(m_prdata),
        .m_apb_pready(m_pready), .m_apb_pslverr(m_pslverr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign init_entry = (int'(init_idx) < N) ? {addr_tab[init_idx], data_tab[init_idx]} : 64'h0;
    assign need       = (!done && int'(init_idx) == wait_entry) ? 5 : 0;
    assign hang_now   = !done && int'(init_idx) == hang_entry;
    assign m_pready   = m_psel && m_penable && !hang_now && (wcnt >= need);
    assign m_pslverr  = m_pready && !done && int'(init_idx) == err_entry;
    assign m_prdata   = 32'hDEAD_BEEF;

    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (m_psel && m_penable && !m_pready) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    always @(negedge clk) begin
        if (!rst && busy) begin
            if (s_pready) stall_viol++;
            if (m_psel && !m_penable) begin
                att_idx.push_back(int'(init_idx));
                cap_addr = m_paddr;
                cap_data = m_pwdata;
            end
            if (m_psel && m_penable) begin
                if (int'(init_idx) < N) acc[init_idx]++;
                if (m_paddr !== cap_addr || m_pwdata !== cap_data) unstable++;
            end
            if (m_psel && m_penable && m_pready) begin
                wr_addr.push_back(m_paddr);
                wr_data.push_back(m_pwdata);
            end
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        att_idx.delete();
        for (int i = 0; i < N; i++) acc[i] = 0;
        unstable   = 0;
        stall_viol = 0;
    endtask

    task automatic release_reset(output int t0);
        @(negedge clk);
        rst = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(output int t1);
        int start;
        start = cyc;
        do begin
            @(posedge clk);
            #1;
        end while (!done && (cyc - start) < 400);
        t1 = cyc;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clear_log();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL reset_busy got=%0b exp=1", busy); end
        n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got=%0b exp=0", done); end
        n_checks++; if (ierr !== 1'b0)     begin n_fail++; $display("FAIL reset_err got=%0b exp=0", ierr); end
        n_checks++; if (err_idx !== 4'd0)  begin n_fail++; $display("FAIL reset_err_idx got=%0d exp=0", err_idx); end
        n_checks++; if (init_idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", init_idx); end
        n_checks++;
        if ({m_psel, m_penable, m_pwrite, m_paddr, m_pwdata} !== 67'h0) begin
            n_fail++; $display("FAIL reset_m_apb got=%0b%0b%0b %h %h exp=0", m_psel, m_penable, m_pwrite, m_paddr, m_pwdata);
        end
        n_checks++; if (s_pready !== 1'b0) begin n_fail++; $display("FAIL reset_s_pready got=%0b exp=0", s_pready); end
    endtask

    task automatic test_zero_wait();
        int t0, t1;
        release_reset(t0);
        wait_done(t1);
        n_checks++; if (t1 - t0 != DL + 3 * N) begin n_fail++; $display("FAIL zw_done_time got=%0d exp=%0d", t1 - t0, DL + 3 * N); end
        n_checks++; if (wr_addr.size() != N) begin n_fail++; $display("FAIL zw_write_count got=%0d exp=%0d", wr_addr.size(), N); end
        else begin
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (wr_addr[i] !== addr_tab[i] || wr_data[i] !== data_tab[i]) begin
                    n_fail++; $display("FAIL zw_entry%0d got=%h/%h exp=%h/%h", i, wr_addr[i], wr_data[i], addr_tab[i], data_tab[i]);
                end
            end
        end
        n_checks++; if (ierr !== 1'b0) begin n_fail++; $display("FAIL zw_err got=%0b exp=0", ierr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zw_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_wait_states();
        int t0, t1;
        apply_reset();
        wait_entry = 2;
        release_reset(t0);
        wait_done(t1);
        wait_entry = -1;
        n_checks++; if (t1 - t0 != DL + 3 * N + 5) begin n_fail++; $display("FAIL ws_done_time got=%0d exp=%0d", t1 - t0, DL + 3 * N + 5); end
        n_checks++; if (acc[2] != 6) begin n_fail++; $display("FAIL ws_penable_cycles got=%0d exp=6", acc[2]); end
        n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL ws_addr_stable got=%0d exp=0", unstable); end
        n_checks++; if (wr_addr.size() != N) begin n_fail++; $display("FAIL ws_write_count got=%0d exp=%0d", wr_addr.size(), N); end
    endtask

    task automatic test_errors();
        int t0, t1;
        apply_reset();
        err_entry  = 3;
        hang_entry = 6;
        release_reset(t0);
        wait_done(t1);
        err_entry  = -1;
        hang_entry = -1;
        n_checks++; if (t1 - t0 != DL + 3 * N + TO - 1) begin n_fail++; $display("FAIL er_done_time got=%0d exp=%0d", t1 - t0, DL + 3 * N + TO - 1); end
        n_checks++; if (ierr !== 1'b1) begin n_fail++; $display("FAIL er_err got=%0b exp=1", ierr); end
        n_checks++; if (err_idx !== 4'd3) begin n_fail++; $display("FAIL er_err_idx got=%0d exp=3", err_idx); end
        n_checks++; if (acc[6] != TO) begin n_fail++; $display("FAIL er_timeout_cycles got=%0d exp=%0d", acc[6], TO); end
        n_checks++; if (att_idx.size() != N) begin n_fail++; $display("FAIL er_attempts got=%0d exp=%0d", att_idx.size(), N); end
        else begin
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (att_idx[i] != i) begin n_fail++; $display("FAIL er_attempt_order%0d got=%0d exp=%0d", i, att_idx[i], i); end
            end
        end
        n_checks++; if (wr_addr.size() != N - 1) begin n_fail++; $display("FAIL er_completions got=%0d exp=%0d", wr_addr.size(), N - 1); end
    endtask

    task automatic test_restart();
        int t0, t1;
        // s_psel high blocks the restart
        @(negedge clk);
        s_psel  = 1'b1;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        s_psel  = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rs_blocked_busy got=%0b exp=0", busy); end
        n_checks++; if (ierr !== 1'b1) begin n_fail++; $display("FAIL rs_blocked_err got=%0b exp=1", ierr); end
        clear_log();
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        restart = 1'b0;
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL rs_edge got=busy%0b done%0b exp=busy1 done0", busy, done); end
        n_checks++; if (ierr !== 1'b0 || err_idx !== 4'd0) begin n_fail++; $display("FAIL rs_err_clear got=%0b/%0d exp=0/0", ierr, err_idx); end
        // pulse while busy must not disturb the run
        repeat (4) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        wait_done(t1);
        n_checks++; if (t1 - t0 != 3 * N) begin n_fail++; $display("FAIL rs_done_time got=%0d exp=%0d", t1 - t0, 3 * N); end
        n_checks++; if (wr_addr.size() != N) begin n_fail++; $display("FAIL rs_write_count got=%0d exp=%0d", wr_addr.size(), N); end
        n_checks++; if (ierr !== 1'b0) begin n_fail++; $display("FAIL rs_err_after got=%0b exp=0", ierr); end
    endtask

    task automatic test_upstream();
        int t0, t1;
        apply_reset();
        s_psel    = 1'b1;
        s_penable = 1'b1;
        s_pwrite  = 1'b0;
        s_paddr   = 32'h0300_0004;
        release_reset(t0);
        wait_done(t1);
        n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL up_stall got=%0d exp=0", stall_viol); end
        n_checks++; if (s_pready !== 1'b1) begin n_fail++; $display("FAIL up_pready got=%0b exp=1", s_pready); end
        n_checks++; if (s_prdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL up_prdata got=%h exp=deadbeef", s_prdata); end
        n_checks++;
        if (m_paddr !== 32'h0300_0004 || m_psel !== 1'b1 || m_pwrite !== 1'b0) begin
            n_fail++; $display("FAIL up_passthru got=%h psel%0b pwrite%0b exp=03000004 psel1 pwrite0", m_paddr, m_psel, m_pwrite);
        end
        @(negedge clk);
        s_psel    = 1'b0;
        s_penable = 1'b0;
    endtask

    task automatic test_reset_mid();
        int t0, t1, k;
        apply_reset();
        release_reset(t0);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!(init_idx == 4'd4 && m_penable) && k < 400);
        n_checks++; if (init_idx !== 4'd4 || m_penable !== 1'b1) begin n_fail++; $display("FAIL rm_reach_access got=idx%0d en%0b exp=idx4 en1", init_idx, m_penable); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (m_psel !== 1'b0 || m_penable !== 1'b0) begin n_fail++; $display("FAIL rm_async_drop got=%0b%0b exp=00", m_psel, m_penable); end
        clear_log();
        release_reset(t0);
        wait_done(t1);
        n_checks++; if (t1 - t0 != DL + 3 * N) begin n_fail++; $display("FAIL rm_done_time got=%0d exp=%0d", t1 - t0, DL + 3 * N); end
        n_checks++; if (wr_addr.size() == 0 || wr_addr[0] !== addr_tab[0]) begin n_fail++; $display("FAIL rm_first_entry got=%0d writes exp=entry0 first", wr_addr.size()); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_errors();
        test_restart();
        test_upstream();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hololink_init_seq.md
Name: hololink_init_seq

Overview:
- APB master sequencer that applies the system-initialization register table after reset, before host traffic begins.
- Each table entry is {32b addr, 32b data}. The block walks entries 0..N_INIT_REG-1 and issues one APB write per entry.
- While it runs, it holds off the upstream (host-side) APB master. When done, it hands the downstream APB bus to that master as a pass-through.
- Sits between the host-interface register master and the internal APB interconnect, in the APB clock domain.

Parameters:
- N_INIT_REG, 9, number of table entries; must be >= 1.
- START_DLY, 64, APB cycles to wait after reset deassertion before entry 0.
- TIMEOUT, 1024, max cycles in ACCESS waiting for pready before the write is abandoned.
- IDX_W, $clog2(N_INIT_REG) (min 1), width of table index.

Ports:
- i_apb_clk  in  1  APB clock; single clock domain.
- i_apb_rst  in  1  reset, asynchronous, active-high.
- o_init_idx  out  IDX_W  table index being fetched.
- i_init_entry  in  64  table entry at o_init_idx; combinational, [63:32]=addr, [31:0]=data.
- i_restart  in  1  single-cycle pulse; re-runs the table from entry 0 (no start delay).
- o_init_busy  out  1  high while sequencing, including the start delay.
- o_init_done  out  1  high after the last entry completes; low while busy.
- o_init_err  out  1  sticky; set on pslverr or timeout; cleared on restart or reset.
- o_err_idx  out  IDX_W  index of the first failing entry since the last restart or reset.
- s_apb_psel, s_apb_penable, s_apb_pwrite  in  1 each  upstream master control.
- s_apb_paddr  in  32  upstream address.
- s_apb_pwdata  in  32  upstream write data.
- s_apb_prdata  out  32  upstream read data.
- s_apb_pready, s_apb_pslverr  out  1 each  upstream response.
- m_apb_psel, m_apb_penable, m_apb_pwrite  out  1 each  downstream control.
- m_apb_paddr  out  32  downstream address.
- m_apb_pwdata  out  32  downstream write data.
- m_apb_prdata  in  32  downstream read data.
- m_apb_pready, m_apb_pslverr  in  1 each  downstream response.

Behaviour:
- Reset values:
  - FSM in WAIT_DLY; delay counter = 0; idx = 0.
  - o_init_busy = 1; o_init_done = 0; o_init_err = 0; o_err_idx = 0.
  - All m_apb_* outputs 0; s_apb_pready = 0.
- WAIT_DLY: counts START_DLY cycles, then moves to SETUP.
- SETUP, 1 cycle:
  - Registers addr/data from i_init_entry.
  - Drives m_psel = 1, m_penable = 0, m_pwrite = 1.
  - Then moves to ACCESS.
- ACCESS:
  - Drives m_penable = 1 and holds addr/data; timeout counter runs.
  - If m_pready = 1: if m_pslverr is also set, record the error; then go to NEXT.
  - If the counter reaches TIMEOUT-1 with no pready: drop psel/penable, record the error, go to NEXT.
- Recording an error: set o_init_err. Load o_err_idx only when o_init_err was previously 0 (first failure wins).
- NEXT, 1 cycle, psel = 0:
  - If idx == N_INIT_REG-1, go to DONE.
  - Otherwise idx++ and go to SETUP.
  - Entries are never retried.
- Per-entry cost: 3 cycles plus pready wait states. Zero-wait-state run: START_DLY + 3*N_INIT_REG cycles from reset release to o_init_done.
- DONE:
  - o_init_busy = 0, o_init_done = 1.
  - Downstream is combinationally muxed to upstream: m_* = s_*, and s_prdata/s_pready/s_pslverr = m_*.
- Not DONE: m_* is driven by the FSM; s_apb_pready = 0 (upstream is stalled, never errored).
- i_restart:
  - Honoured only in DONE with s_apb_psel = 0. Otherwise ignored; no queuing.
  - When honoured: clears o_init_err/o_err_idx, sets idx = 0, goes to SETUP.
  - o_init_busy rises and o_init_done falls on the next edge.
- Reset mid-transfer: APB signals drop asynchronously; the sequence restarts from WAIT_DLY.
- Width rules:
  - Timeout counter width is $clog2(TIMEOUT+1); saturates, never wraps.
  - Delay counter width is $clog2(START_DLY+1).
  - START_DLY = 0 goes directly to SETUP.

Decomposition:
- Shared package gets:
  - The FSM state enum (WAIT_DLY, SETUP, ACCESS, NEXT, DONE).
  - An init-entry struct {addr[31:0], data[31:0]}.
  - INIT_TIMEOUT and INIT_START_DLY constants.
- The table itself stays in the existing system package; the top level drives i_init_entry from it via o_init_idx.
- No sub-module; the pass-through mux is inline.

Test Plan:
- 9-entry table, zero-wait slave, START_DLY = 64 -> nine writes in index order with exact addr/data (e.g. entry 0: 0x0300_0210 / 0x004C_4B40); o_init_done high at cycle 64 + 27; o_init_err = 0.
- Slave inserts 5 wait states on entry 2 -> penable is held for 6 cycles with addr/data stable; the total run extends by 5 cycles.
- pslverr on entry 3, slave never answers entry 6, TIMEOUT = 16 -> entry 6 psel drops after 16 ACCESS cycles; o_init_err = 1; o_err_idx = 3; all 9 entries attempted.
- Upstream psel asserted during init -> s_apb_pready stays 0 until DONE; the transfer then completes via pass-through with prdata = 0xDEAD_BEEF from the slave.
- i_restart while DONE and s_psel = 0 -> the table is replayed with no start delay and err is cleared. i_restart during busy, or with s_psel = 1 -> ignored.
- Reset asserted in ACCESS of entry 4 -> m_psel/penable go to 0 immediately; after release, the sequence restarts from entry 0 after START_DLY.
